// File: rtl/hex_word_loader_if.sv
// hex_word_loader_if: byte-stream and memory-write bundle for hex_word_loader.
//   rx_data/rx_valid/rx_ack : UART receiver side (dout, rdy, rdy_clr)
//   tx_data/tx_wr/tx_busy   : UART transmitter side for echo (din, wr_en, busy)
//   mem_we/mem_addr/mem_wdata : instruction memory write port
// slave modport is the loader; master modport is the UART/memory environment.
interface hex_word_loader_if #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned DEPTH  = 16
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ack;
   logic [7:0]        tx_data;
   logic              tx_wr;
   logic              tx_busy;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;

   modport master (
      output rx_data, rx_valid, tx_busy,
      input  rx_ack, tx_data, tx_wr, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  rx_data, rx_valid, tx_busy,
      output rx_ack, tx_data, tx_wr, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/hex_word_loader.sv
// hex_word_loader: packs ASCII hex from a UART receiver MSB-nibble-first into
// WORD_W-bit words and writes them to a DEPTH-entry instruction memory.
// Commands: '@' set address, '$' load complete, 'X'/'x' abort partial word.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : synchronous restart, same effect as reset
//   bus (slave)   : rx byte handshake, tx echo, memory write port
//   word_count    : words written, saturates at DEPTH
//   load_done     : level, set by '$'
//   err_bad_char  : sticky, unrecognised byte seen
//   err_overflow  : sticky, write or address beyond DEPTH
// Optional feature: define HEXLOAD_ECHO_EN to echo every accepted byte.
module hex_word_loader #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   hex_word_loader_if.slave       bus,
   output logic [$clog2(DEPTH):0] word_count,
   output logic                   load_done,
   output logic                   err_bad_char,
   output logic                   err_overflow
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam int unsigned ACC_W  = ADDR_W + 4;
   localparam int unsigned NDIG   = WORD_W / 4;
   localparam int unsigned DCNT_W = $clog2(NDIG + 1);

   typedef enum logic [1:0] {IDLE, DATA, ADDR, DONE} state_t;

   state_t            state, state_n;
   logic [PTR_W-1:0]  ptr, ptr_n;
   logic [DCNT_W-1:0] dcnt, dcnt_n;
   logic [WORD_W-1:0] shift, shift_n;
   logic [ACC_W-1:0]  acc, acc_n;
   logic [PTR_W-1:0]  wc_n;
   logic              done_n, ebad_n, eovf_n;
   logic              we, we_n;
   logic [ADDR_W-1:0] maddr, maddr_n;
   logic [WORD_W-1:0] wdata, wdata_n;
   logic              ack, ack_n;

   logic              ready, accept;
   logic [7:0]        c;
   logic              is_dig, is_up, is_lo, is_hex, is_ws, is_at, is_dol, is_x;
   logic [3:0]        nib;
   logic [WORD_W-1:0] word_c;

   // Byte acceptance; ack register doubles as the ack-pending flag
`ifdef HEXLOAD_ECHO_EN
   logic       tx_wr_q, tx_wr_n;
   logic [7:0] tx_data_q, tx_data_n;
   assign ready = !bus.tx_busy && !tx_wr_q && !ack;
`else
   logic unused_tx_busy;
   assign unused_tx_busy = bus.tx_busy;
   assign ready = !ack;
`endif
   assign accept = bus.rx_valid && ready && !clear;

   // Character classification and nibble decode
   assign c      = bus.rx_data;
   assign is_dig = (c >= 8'h30) && (c <= 8'h39);
   assign is_up  = (c >= 8'h41) && (c <= 8'h46);
   assign is_lo  = (c >= 8'h61) && (c <= 8'h66);
   assign is_hex = is_dig || is_up || is_lo;
   assign is_ws  = (c == 8'h20) || (c == 8'h0D) || (c == 8'h0A) || (c == 8'h09);
   assign is_at  = (c == 8'h40);
   assign is_dol = (c == 8'h24);
   assign is_x   = (c == 8'h58) || (c == 8'h78);
   assign nib    = is_dig ? 4'(c - 8'h30) : (is_up ? 4'(c - 8'h37) : 4'(c - 8'h57));
   assign word_c = {shift[WORD_W-5:0], nib};

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptr          <= '0;
         dcnt         <= '0;
         shift        <= '0;
         acc          <= '0;
         word_count   <= '0;
         load_done    <= 1'b0;
         err_bad_char <= 1'b0;
         err_overflow <= 1'b0;
         we           <= 1'b0;
         maddr        <= '0;
         wdata        <= '0;
         ack          <= 1'b0;
`ifdef HEXLOAD_ECHO_EN
         tx_wr_q      <= 1'b0;
         tx_data_q    <= '0;
`endif
      end else if (clear) begin
         state        <= IDLE;
         ptr          <= '0;
         dcnt         <= '0;
         shift        <= '0;
         acc          <= '0;
         word_count   <= '0;
         load_done    <= 1'b0;
         err_bad_char <= 1'b0;
         err_overflow <= 1'b0;
         we           <= 1'b0;
         maddr        <= '0;
         wdata        <= '0;
         ack          <= 1'b0;
`ifdef HEXLOAD_ECHO_EN
         tx_wr_q      <= 1'b0;
         tx_data_q    <= '0;
`endif
      end else begin
         state        <= state_n;
         ptr          <= ptr_n;
         dcnt         <= dcnt_n;
         shift        <= shift_n;
         acc          <= acc_n;
         word_count   <= wc_n;
         load_done    <= done_n;
         err_bad_char <= ebad_n;
         err_overflow <= eovf_n;
         we           <= we_n;
         maddr        <= maddr_n;
         wdata        <= wdata_n;
         ack          <= ack_n;
`ifdef HEXLOAD_ECHO_EN
         tx_wr_q      <= tx_wr_n;
         tx_data_q    <= tx_data_n;
`endif
      end
   end

   // Next-state and datapath update for one accepted byte
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      dcnt_n  = dcnt;
      shift_n = shift;
      acc_n   = acc;
      wc_n    = word_count;
      done_n  = load_done;
      ebad_n  = err_bad_char;
      eovf_n  = err_overflow;
      we_n    = 1'b0;
      maddr_n = maddr;
      wdata_n = wdata;
      ack_n   = accept;
`ifdef HEXLOAD_ECHO_EN
      tx_wr_n   = accept;
      tx_data_n = accept ? c : tx_data_q;
`endif
      if (accept) begin
         case (state)
            IDLE, DATA: begin
               state_n = DATA;
               if (is_hex) begin
                  shift_n = word_c;
                  if (dcnt == DCNT_W'(NDIG - 1)) begin
                     dcnt_n = '0;
                     if (ptr < PTR_W'(DEPTH)) begin
                        we_n    = 1'b1;
                        maddr_n = ptr[ADDR_W-1:0];
                        wdata_n = word_c;
                        ptr_n   = ptr + PTR_W'(1);
                        if (word_count < PTR_W'(DEPTH))
                           wc_n = word_count + PTR_W'(1);
                     end else begin
                        eovf_n = 1'b1;
                     end
                  end else begin
                     dcnt_n = dcnt + DCNT_W'(1);
                  end
               end else if (is_ws) begin
                  state_n = DATA;
               end else if (is_x) begin
                  dcnt_n  = '0;
                  shift_n = '0;
               end else if (is_at) begin
                  dcnt_n  = '0;
                  shift_n = '0;
                  acc_n   = '0;
                  state_n = ADDR;
               end else if (is_dol) begin
                  dcnt_n  = '0;
                  shift_n = '0;
                  done_n  = 1'b1;
                  state_n = DONE;
               end else begin
                  ebad_n = 1'b1;
               end
            end
            ADDR: begin
               if (is_hex) begin
                  acc_n = {acc[ADDR_W-1:0], nib};
               end else if (is_ws || is_dol) begin
                  // Out-of-range address parks ptr at DEPTH so all writes stay suppressed
                  if (acc >= ACC_W'(DEPTH)) begin
                     ptr_n  = PTR_W'(DEPTH);
                     eovf_n = 1'b1;
                  end else begin
                     ptr_n = PTR_W'(acc);
                  end
                  if (is_dol) begin
                     done_n  = 1'b1;
                     state_n = DONE;
                  end else begin
                     state_n = DATA;
                  end
               end else if (is_at || is_x) begin
                  acc_n = '0;
               end else begin
                  ebad_n = 1'b1;
               end
            end
            DONE: state_n = DONE;
            default: state_n = IDLE;
         endcase
      end
   end

   assign bus.rx_ack    = ack;
   assign bus.mem_we    = we;
   assign bus.mem_addr  = maddr;
   assign bus.mem_wdata = wdata;
`ifdef HEXLOAD_ECHO_EN
   assign bus.tx_wr     = tx_wr_q;
   assign bus.tx_data   = tx_data_q;
`else
   assign bus.tx_wr     = 1'b0;
   assign bus.tx_data   = 8'h00;
`endif
endmodule

// File: tb/tb_hex_word_loader.sv
// tb_hex_word_loader: directed byte streams with a write scoreboard; expected
// memory writes are queued by the stimulus and popped by a negedge monitor.
module tb_hex_word_loader;
   localparam int unsigned W  = 32;
   localparam int unsigned D  = 16;
   localparam int unsigned AW = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic [AW:0] word_count;
   logic        load_done, err_bad_char, err_overflow;

   int checks   = 0;
   int failures = 0;
   wr_t exp_q[$];
   logic [7:0] echo_q[$];
   wr_t mon_e;
   logic [7:0] mon_b;

   hex_word_loader_if #(.WORD_W(W), .DEPTH(D)) bus ();

   hex_word_loader #(.WORD_W(W), .DEPTH(D)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .bus          (bus.slave),
      .word_count   (word_count),
      .load_done    (load_done),
      .err_bad_char (err_bad_char),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [W-1:0] d);
      exp_q.push_back(wr_t'{addr: a, data: d});
   endtask

   // UART receiver model: hold rx_valid until rx_ack is seen
   task automatic send_byte(input logic [7:0] b);
      int n;
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.rx_ack && n < 50);
      if (!bus.rx_ack) begin
         checks++;
         failures++;
         $display("FAIL ack_timeout actual=no_ack required=ack byte=%0h", b);
      end
`ifdef HEXLOAD_ECHO_EN
      else echo_q.push_back(b);
`endif
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic drain(input string name);
      repeat (3) @(negedge clk);
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
      chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
      chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
      chk({tag, "_word_count"}, 64'(word_count), 64'd0);
      chk({tag, "_flags"}, 64'({load_done, err_bad_char, err_overflow}), 64'd0);
      chk({tag, "_rx_ack"}, 64'(bus.rx_ack), 64'd0);
      chk({tag, "_tx"}, 64'({bus.tx_wr, bus.tx_data}), 64'd0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && bus.mem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual addr=%0h data=%0h required none",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
            chk("wr_data", 64'(bus.mem_wdata), 64'(mon_e.data));
            chk("wr_latency", 64'(bus.rx_ack), 64'd1);
         end
      end
      if (rst_n && bus.tx_wr) begin
`ifdef HEXLOAD_ECHO_EN
         chk("echo_with_ack", 64'(bus.rx_ack), 64'd1);
         if (echo_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_echo actual=%0h required none", bus.tx_data);
         end else begin
            mon_b = echo_q.pop_front();
            chk("echo_data", 64'(bus.tx_data), 64'(mon_b));
         end
`else
         chk("tx_wr_tied", 64'(bus.tx_wr), 64'd0);
`endif
      end
   end

   initial begin
      #200_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic bad;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.tx_busy  = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("post_reset");

      // Single word
      push(4'h0, 32'hDEADBEEF);
      send_str("DEADBEEF");
      drain("deadbeef_drain");
      chk("deadbeef_count", 64'(word_count), 64'd1);

      // Address command, then lowercase continuation
      do_clear();
      push(4'hA, 32'h12345678);
      send_str("@A 12345678");
      push(4'hB, 32'hCAFEF00D);
      send_str("cafef00d");
      drain("addr_drain");
      chk("addr_count", 64'(word_count), 64'd2);
      chk("addr_flags", 64'({err_bad_char, err_overflow}), 64'd0);

      // Fill memory and overflow
      do_clear();
      for (int i = 0; i < 16; i++) begin
         push(AW'(i), 32'h11111111);
         send_str("11111111");
      end
      chk("full_no_ovf", 64'(err_overflow), 64'd0);
      send_str("11111111");
      drain("full_drain");
      chk("full_ovf", 64'(err_overflow), 64'd1);
      chk("full_count", 64'(word_count), 64'd16);

      // Bad character kept partial, 'X' aborts
      do_clear();
      push(4'h0, 32'h00000001);
      send_str("12G3X00000001");
      drain("bad_drain");
      chk("bad_flag", 64'(err_bad_char), 64'd1);
      chk("bad_count", 64'(word_count), 64'd1);

      // Last valid address, then overflow
      do_clear();
      push(4'hF, 32'h0000000A);
      send_str("@F 0000000A 0000000B");
      drain("edge_drain");
      chk("edge_ovf", 64'(err_overflow), 64'd1);
      chk("edge_count", 64'(word_count), 64'd1);

      // Out-of-range address suppresses writes
      do_clear();
      send_str("@1F 22222222");
      drain("addr_ovf_drain");
      chk("addr_ovf_flag", 64'(err_overflow), 64'd1);

      // Load complete, then clear restarts at address 0
      do_clear();
      send_str("1234$5678ABCD");
      drain("done_drain");
      chk("done_flag", 64'(load_done), 64'd1);
      chk("done_count", 64'(word_count), 64'd0);
      do_clear();
      chk("clear_done", 64'(load_done), 64'd0);
      chk("clear_count", 64'(word_count), 64'd0);
      push(4'h0, 32'h00000007);
      send_str("00000007");
      drain("restart_drain");

      // Transmitter busy
      do_clear();
`ifdef HEXLOAD_ECHO_EN
      @(negedge clk);
      bus.tx_busy  = 1'b1;
      bus.rx_data  = 8'h41;
      bus.rx_valid = 1'b1;
      bad = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (bus.rx_ack || bus.tx_wr) bad = 1'b1;
      end
      chk("busy_hold", 64'(bad), 64'd0);
      bus.tx_busy = 1'b0;
      echo_q.push_back(8'h41);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.rx_ack && n < 50);
      chk("busy_release_ack", 64'(bus.rx_ack), 64'd1);
      chk("busy_release_txwr", 64'(bus.tx_wr), 64'd1);
      chk("busy_release_data", 64'(bus.tx_data), 64'h41);
      bus.rx_valid = 1'b0;
`else
      bus.tx_busy = 1'b1;
      send_byte(8'h41);
      chk("busy_ignored_txwr", 64'(bus.tx_wr), 64'd0);
      chk("busy_ignored_txdata", 64'(bus.tx_data), 64'd0);
      bus.tx_busy = 1'b0;
`endif
      do_clear();

      // Reset mid-word discards the partial word
      push(4'h0, 32'h00000009);
      send_str("00000009");
      send_str("ABCD");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      push(4'h0, 32'h00000005);
      send_str("00000005");
      drain("after_reset_drain");
      chk("after_reset_count", 64'(word_count), 64'd1);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
